scratchpad_backdoor_arbiter: RTL and testbench
==============================================

Name: scratchpad_backdoor_arbiter

Overview:
Shares the 64-bit backdoor access path into the scratchpad (main) memory wrapper between NUM_REQ requesters: the system thread, CPU drivers and the program loader.
- Replaces ad-hoc concurrent forcing of scratchpad signals with a single sequenced owner.
- Round-robin arbitration; one transaction in flight.
- Sequences registered-read timing and waits out memory reset.
- Sits between the testbench driver layer and the scratchpad wrapper override inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, byte address width
DATA_W, 64, data width; all backdoor accesses are full-width
MASK_W, DATA_W/8, byte-mask width; always driven all-ones

Ports:
clk  in  1  memory-domain clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
rsp_err  out  1  qualifies rsp_valid; 1 = aborted by memory reset
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
mem_rst_i  in  1  scratchpad wrapper reset, active-high
mem_sel_o  out  1  backdoor override active (state != IDLE)
mem_write_o  out  1  scratchpad write strobe
mem_mask_o  out  MASK_W  byte mask
mem_addr_o  out  ADDR_W  scratchpad address
mem_wdata_o  out  DATA_W  write data
mem_rdata_i  in  DATA_W  registered scratchpad read data

Behaviour:
- Reset (rst_n low, async): state=IDLE; rr_ptr=0; all outputs 0 (req_ready, rsp_valid, rsp_err, rsp_rdata, mem_*); captured request registers 0.
- FSM states: IDLE, WR, RD_ADDR, RD_DATA.
- IDLE:
  - If mem_rst_i=1, no grant.
  - Otherwise select the first requester with req_valid set, searching circularly from rr_ptr.
  - req_ready[g] is combinational in IDLE only; handshake occurs in the same cycle (T).
  - Capture g, write, addr, wdata. Set rr_ptr=(g+1) mod NUM_REQ; wrap from NUM_REQ-1 to 0.
  - Go to WR if write, else RD_ADDR.
- WR (T+1): mem_sel_o=1, mem_write_o=1, mem_mask_o=all-ones, addr and wdata driven. Next state IDLE. rsp_valid[g]=1 at T+2, rsp_err=0.
- RD_ADDR (T+1): mem_sel_o=1, mem_write_o=0, addr driven. Next state RD_DATA.
- RD_DATA (T+2): addr held; sample mem_rdata_i into rsp_rdata. Next state IDLE. rsp_valid[g]=1 with rsp_rdata at T+3.
- Throughput: write turnaround 2 cycles; read turnaround 3 cycles. A new grant may occur in the same cycle as the previous rsp_valid.
- rsp_valid, rsp_err and rsp_rdata are registered. rsp_rdata holds its value until the next read completes; it is unchanged by writes.
- mem_rst_i rising while in WR, RD_ADDR or RD_DATA:
  - Abort the transaction; next state IDLE.
  - rsp_valid[g]=1 and rsp_err=1 next cycle; rsp_rdata unchanged.
  - No memory strobe in the cycle after the abort.
- rst_n asserted mid-transaction: immediate return to reset values. No response is issued.
- A requester may drop req_valid before it is granted (no penalty). Requests are not queued; a requester must hold req_valid until req_ready.
- When not in WR/RD_*, mem_write_o=0, mem_mask_o=0, mem_addr_o=0, mem_wdata_o=0 (no X on override path).
- Simultaneous req_valid from all requesters: grants are strictly rotating; no requester waits more than NUM_REQ grants.

Decomposition:
- Shared package cep_backdoor_pkg:
  - bd_state_e enum (IDLE, WR, RD_ADDR, RD_DATA).
  - bd_req_t struct {write, addr, wdata}.
  - BD_ADDR_W and BD_DATA_W constants.
- One sub-module, cep_rr_arbiter:
  - Parameterised NUM_REQ.
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant and binary index (combinational).

Test Plan:
- Single write: requester 0 writes addr 0x0000_0100, data 0xDEAD_BEEF_0123_4567 -> mem_write_o high exactly one cycle (T+1) with mask 0xFF; rsp_valid[0] at T+2, rsp_err=0.
- Single read: scratchpad preloaded with 0xCAFE_F00D_0000_0001 at 0x100; requester 2 reads -> mem_write_o stays 0; rsp_valid[2] at T+3 with rsp_rdata=0xCAFE_F00D_0000_0001.
- All four requesters valid at once after reset -> grant order 0,1,2,3; requester 0 re-requests -> next grant is 0 only after 3.
- Persistent requester 1 plus late requester 3 -> requester 3 is granted within the next 2 grants, with no starvation.
- mem_rst_i pulses during RD_DATA -> next cycle rsp_valid[g]=1, rsp_err=1; FSM in IDLE; no grant while mem_rst_i=1; first grant follows the mem_rst_i deassertion.
- rst_n low during WR -> all outputs 0 asynchronously; no rsp_valid; after release the first grant goes to requester 0.

Source files
------------

// File: rtl/cep_backdoor_pkg.sv
// Shared types for the scratchpad backdoor path.
//   bd_state_e     : sequencer states of the backdoor owner
//   bd_req_t       : one captured backdoor request (write flag, address, data)
//   BD_ADDR_W/DATA_W : native widths of the scratchpad override port
//   rr_wrap_inc    : circular increment used for the round-robin pointer
package cep_backdoor_pkg;

  localparam int BD_ADDR_W = 32;
  localparam int BD_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_DATA
  } bd_state_e;

  typedef struct packed {
    logic                 write;
    logic [BD_ADDR_W-1:0] addr;
    logic [BD_DATA_W-1:0] wdata;
  } bd_req_t;

  // Next requester index after idx, wrapping from n-1 back to 0.
  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cep_rr_arbiter.sv
// Combinational round-robin picker.
//   req       : per-requester request vector
//   rr_ptr    : index searched first; search continues circularly
//   enable    : when low no grant is produced
//   grant     : one-hot grant (or zero)
//   grant_idx : binary index of the granted requester (0 when no grant)
module cep_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    // NOTE: every output and temporary gets a default before the search so no path infers a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // rr_ptr + k is below 2*NUM_REQ, so a single subtraction wraps it.
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (enable && !found && req[cand[IDX_W-1:0]]) begin
        found                     = 1'b1;
        grant[cand[IDX_W-1:0]]    = 1'b1;
        grant_idx                 = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/scratchpad_backdoor_arbiter.sv
// Single-owner sequencer for the 64-bit scratchpad backdoor override port.
// Requesters are served round-robin, one transaction at a time.
//   req_valid/req_ready/req_write/req_addr/req_wdata : per-requester request side
//                                                     (addr/wdata packed, requester i at slice i)
//   rsp_valid/rsp_err/rsp_rdata : registered completion; rsp_err marks a memory-reset abort
//   mem_rst_i                   : scratchpad wrapper reset (active high)
//   mem_sel_o/mem_write_o/mem_mask_o/mem_addr_o/mem_wdata_o : override drive, zero when idle
//   mem_rdata_i                 : registered scratchpad read data
module scratchpad_backdoor_arbiter
  import cep_backdoor_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = BD_ADDR_W,
  parameter int DATA_W  = BD_DATA_W,
  parameter int MASK_W  = DATA_W / 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         rsp_rdata,
  input  logic                      mem_rst_i,
  output logic                      mem_sel_o,
  output logic                      mem_write_o,
  output logic [MASK_W-1:0]         mem_mask_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic [DATA_W-1:0]         mem_rdata_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  bd_state_e          state, state_d;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] owner;
  logic               grant_any;
  logic               busy;
  bd_req_t            cap;

  // Grants only from IDLE, never while the memory is in reset, and never while
  // rst_n is low so req_ready reads zero during reset like every other output.
  cep_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .enable    ((state == IDLE) && !mem_rst_i && rst_n),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign grant_any = |grant;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (grant_any) state_d = req_write[grant_idx] ? WR : RD_ADDR;
      WR:      state_d = IDLE;
      RD_ADDR: state_d = mem_rst_i ? IDLE : RD_DATA;
      RD_DATA: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      cap       <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state     <= state_d;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      if (grant_any) begin
        owner     <= grant;
        rr_ptr    <= IDX_W'(rr_wrap_inc(32'(grant_idx), NUM_REQ));
        cap.write <= req_write[grant_idx];
        cap.addr  <= req_addr[32'(grant_idx)*ADDR_W +: ADDR_W];
        cap.wdata <= req_wdata[32'(grant_idx)*DATA_W +: DATA_W];
      end
      // A memory reset during any busy state completes the owner with rsp_err
      // and leaves rsp_rdata holding the last good read.
      unique case (state)
        WR: begin
          rsp_valid <= owner;
          rsp_err   <= mem_rst_i;
        end
        RD_ADDR: if (mem_rst_i) begin
          rsp_valid <= owner;
          rsp_err   <= 1'b1;
        end
        RD_DATA: begin
          rsp_valid <= owner;
          rsp_err   <= mem_rst_i;
          if (!mem_rst_i) rsp_rdata <= mem_rdata_i;
        end
        default: ;
      endcase
    end
  end

  // Override drive is derived from state so nothing but zeros leaves the
  // block while idle, including the cycle right after an abort.
  assign busy        = (state != IDLE);
  assign mem_sel_o   = busy;
  assign mem_write_o = (state == WR) && cap.write;
  assign mem_mask_o  = busy ? '1 : '0;
  assign mem_addr_o  = busy ? cap.addr : '0;
  assign mem_wdata_o = (state == WR) ? cap.wdata : '0;

endmodule

// File: tb/tb_scratchpad_backdoor_arbiter.sv
module tb_scratchpad_backdoor_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    rsp_valid;
  logic            rsp_err;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_rst_i = 1'b0;
  logic            mem_sel_o;
  logic            mem_write_o;
  logic [MW-1:0]   mem_mask_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o;
  logic [DW-1:0]   mem_rdata_i = '0;

  scratchpad_backdoor_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_rdata   (rsp_rdata),
    .mem_rst_i   (mem_rst_i),
    .mem_sel_o   (mem_sel_o),
    .mem_write_o (mem_write_o),
    .mem_mask_o  (mem_mask_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Scratchpad environment: write on strobe, registered read of the presented address.
  logic [DW-1:0] sp_mem [logic [AW-1:0]];
  always @(posedge clk) begin
    if (mem_sel_o && mem_write_o) sp_mem[mem_addr_o] = mem_wdata_o;
    mem_rdata_i <= sp_mem.exists(mem_addr_o) ? sp_mem[mem_addr_o] : '0;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Arbitration table: all-write requests applied from reset.
  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] exp_ready;
  } vec_t;
  vec_t tbl [11];

  // Random-phase reference model state (transaction level).
  bit            pend [N];
  bit            p_wr [N];
  int            p_k  [N];
  logic [DW-1:0] p_data [N];
  logic [DW-1:0] ref_mem [8];
  int            rr, free_at, g_cyc, rsp_cyc, g;
  bit            g_wr, rsp_rd;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_data, rsp_exp, last_rdata;
  logic [N-1:0]  rsp_vec, exp_ready, exp_rv;
  bit            exp_sel;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0001};  // requester 0 again only after 3
    tbl[5]  = '{4'b0010, 4'b0010};
    tbl[6]  = '{4'b1010, 4'b1000};  // late requester 3 beats persistent 1
    tbl[7]  = '{4'b0010, 4'b0010};
    tbl[8]  = '{4'b0000, 4'b0000};
    tbl[9]  = '{4'b1001, 4'b1000};
    tbl[10] = '{4'b1001, 4'b0001};

    // ---- reset values, with requests already asserted ----
    req_valid = '1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_mem_sel", mem_sel_o, 0);
    check("rst_mem_write", mem_write_o, 0);
    check("rst_mem_mask", mem_mask_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_wdata", mem_wdata_o, 0);
    req_valid = '0;
    rst_n = 1'b1;

    // ---- table-driven arbitration order ----
    for (int e = 0; e < 11; e++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (tbl[e].valid[i]) set_req(i, 1'b1, 32'h200 + 32'(8*i), {32'hA5A5_0000, 32'(e)});
      #1;
      check($sformatf("tbl%0d_ready", e), req_ready, tbl[e].exp_ready);
      @(negedge clk);
      req_valid = '0;
      check($sformatf("tbl%0d_write", e), mem_write_o, (tbl[e].exp_ready != 0));
      @(negedge clk);
      check($sformatf("tbl%0d_rsp", e), rsp_valid, tbl[e].exp_ready);
    end

    // ---- single write from requester 0 ----
    @(negedge clk);
    set_req(0, 1'b1, 32'h0000_0100, 64'hDEAD_BEEF_0123_4567);
    #1 check("wr_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    check("wr_sel", mem_sel_o, 1);
    check("wr_strobe", mem_write_o, 1);
    check("wr_mask", mem_mask_o, 8'hFF);
    check("wr_addr", mem_addr_o, 32'h100);
    check("wr_wdata", mem_wdata_o, 64'hDEAD_BEEF_0123_4567);
    @(negedge clk);
    check("wr_strobe_once", mem_write_o, 0);
    check("wr_rsp", rsp_valid, 4'b0001);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_mem_content", sp_mem[32'h100], 64'hDEAD_BEEF_0123_4567);

    // ---- single read from requester 2 ----
    sp_mem[32'h100] = 64'hCAFE_F00D_0000_0001;
    set_req(2, 1'b0, 32'h0000_0100, 64'h0);
    #1 check("rd_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    check("rd_sel_a", mem_sel_o, 1);
    check("rd_nowrite_a", mem_write_o, 0);
    check("rd_addr_a", mem_addr_o, 32'h100);
    @(negedge clk);
    check("rd_nowrite_d", mem_write_o, 0);
    check("rd_addr_d", mem_addr_o, 32'h100);
    check("rd_rsp_early", rsp_valid, 0);
    @(negedge clk);
    check("rd_rsp", rsp_valid, 4'b0100);
    check("rd_rdata", rsp_rdata, 64'hCAFE_F00D_0000_0001);
    check("rd_rsp_err", rsp_err, 0);
    check("rd_idle", mem_sel_o, 0);

    // ---- memory reset during RD_DATA ----
    set_req(1, 1'b0, 32'h0000_0108, 64'h0);
    #1 check("abort_ready", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    mem_rst_i = 1'b1;
    set_req(3, 1'b1, 32'h0000_0118, 64'h1111_2222_3333_4444);
    @(negedge clk);
    check("abort_rsp", rsp_valid, 4'b0010);
    check("abort_err", rsp_err, 1);
    check("abort_rdata_held", rsp_rdata, 64'hCAFE_F00D_0000_0001);
    check("abort_sel", mem_sel_o, 0);
    check("abort_nostrobe", mem_write_o, 0);
    #1 check("abort_nogrant", req_ready, 0);
    @(negedge clk);
    check("abort_rsp_once", rsp_valid, 0);
    check("abort_err_clr", rsp_err, 0);
    check("abort_nogrant2", req_ready, 0);
    mem_rst_i = 1'b0;
    #1 check("abort_regrant", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = '0;
    check("abort_post_write", mem_write_o, 1);
    @(negedge clk);
    check("abort_post_rsp", rsp_valid, 4'b1000);

    // ---- rst_n during WR ----
    set_req(2, 1'b1, 32'h0000_0110, 64'h5555_6666_7777_8888);
    #1 check("rstwr_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    check("rstwr_strobe", mem_write_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstwr_sel", mem_sel_o, 0);
    check("rstwr_write", mem_write_o, 0);
    check("rstwr_mask", mem_mask_o, 0);
    check("rstwr_addr", mem_addr_o, 0);
    check("rstwr_wdata", mem_wdata_o, 0);
    check("rstwr_rdata", rsp_rdata, 0);
    @(negedge clk);
    check("rstwr_norsp", rsp_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h300 + 32'(8*i), 64'(i));
    #1 check("rstwr_first_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check("rstwr_first_rsp", rsp_valid, 4'b0001);

    // ---- randomized traffic against a transaction-level model ----
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ref_mem[k] = {$urandom, $urandom};
      sp_mem[32'h100 + 32'(8*k)] = ref_mem[k];
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    rr = 0; free_at = 0; g_cyc = -10; rsp_cyc = -1;
    g_wr = 1'b0; rsp_rd = 1'b0; rsp_vec = '0; last_rdata = '0;
    g_addr = '0; g_data = '0; rsp_exp = '0;

    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      exp_rv = (c == rsp_cyc) ? rsp_vec : '0;
      if (c == rsp_cyc && rsp_rd) last_rdata = rsp_exp;
      exp_sel = (c > g_cyc) && (c < free_at);
      check("rnd_rsp_valid", rsp_valid, exp_rv);
      check("rnd_rsp_err", rsp_err, 0);
      check("rnd_rsp_rdata", rsp_rdata, last_rdata);
      check("rnd_mem_sel", mem_sel_o, exp_sel);
      check("rnd_mem_mask", mem_mask_o, exp_sel ? 8'hFF : 8'h00);
      check("rnd_mem_write", mem_write_o, (c == g_cyc + 1) && g_wr);
      check("rnd_mem_wdata", mem_wdata_o, ((c == g_cyc + 1) && g_wr) ? g_data : '0);
      check("rnd_mem_addr", mem_addr_o, exp_sel ? g_addr : '0);

      for (int i = 0; i < N; i++) begin
        if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]   = 1'b1;
          p_wr[i]   = 1'($urandom_range(0, 1));
          p_k[i]    = int'($urandom_range(0, 7));
          p_data[i] = {$urandom, $urandom};
        end
        req_valid[i]          = pend[i];
        req_write[i]          = p_wr[i];
        req_addr[i*AW +: AW]  = 32'h100 + 32'(8 * p_k[i]);
        req_wdata[i*DW +: DW] = p_data[i];
      end
      #1;
      exp_ready = '0;
      g = -1;
      if (c >= free_at)
        for (int k = 0; k < N; k++)
          if (g < 0 && pend[(rr + k) % N]) g = (rr + k) % N;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("rnd_req_ready", req_ready, exp_ready);
      if (g >= 0) begin
        rr      = (g + 1) % N;
        pend[g] = 1'b0;
        g_cyc   = c;
        g_wr    = p_wr[g];
        g_addr  = 32'h100 + 32'(8 * p_k[g]);
        g_data  = p_data[g];
        rsp_vec = exp_ready;
        rsp_rd  = !p_wr[g];
        if (p_wr[g]) begin
          ref_mem[p_k[g]] = p_data[g];
          free_at = c + 2;
        end else begin
          rsp_exp = ref_mem[p_k[g]];
          free_at = c + 3;
        end
        rsp_cyc = free_at;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
